// File: rtl/trigger_matrix_core_pkg.sv
// Shared types for the trigger crossbar: output modes, config word layout
// and the packed per-channel configuration record.
package trigger_matrix_core_pkg;

  typedef enum logic [1:0] {
    XBAR_DIRECT = 2'b00,
    XBAR_PULSE  = 2'b01,
    XBAR_RSVD   = 2'b10,
    XBAR_OFF    = 2'b11
  } xbar_mode_e;

  localparam int CFG_SRC_LSB  = 0;
  localparam int CFG_SRC_W    = 8;
  localparam int CFG_INV_BIT  = 8;
  localparam int CFG_MODE_LSB = 9;
  localparam int CFG_MODE_W   = 2;

  typedef struct packed {
    xbar_mode_e mode;
    logic       invert;
    logic [7:0] src;
  } xbar_cfg_t;

  localparam xbar_cfg_t XBAR_CFG_RESET = '{mode: XBAR_OFF, invert: 1'b0, src: 8'h00};

  // Reserved bits [15:11] always read back as zero.
  function automatic logic [15:0] cfg_pack(input xbar_cfg_t c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/trigger_matrix_core_stretcher.sv
// Activity stretcher: any edge on sig reloads a hold down-counter; led is
// high while the counter is nonzero.
module trigger_activity_stretcher #(
  parameter int HOLD = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic led
);

  localparam int CW = $clog2(HOLD + 1);

  logic          sig_prev;
  logic [CW-1:0] hold_cnt;
  logic          edge_seen;

  assign edge_seen = sig ^ sig_prev;

  // led is registered alongside the counter so it always equals (hold_cnt != 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_prev <= 1'b0;
      hold_cnt <= '0;
      led      <= 1'b0;
    end else begin
      sig_prev <= sig;
      if (edge_seen) begin
        hold_cnt <= CW'(HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CW'(1);
      end
      led <= edge_seen | (hold_cnt > CW'(1));
    end
  end

endmodule

// File: rtl/trigger_matrix_core.sv
// Runtime-configurable trigger crossbar: NUM_IN synchronised inputs routed to
// NUM_OUT outputs with per-channel source, inversion and direct/pulse/off mode.
module trigger_matrix_core
  import trigger_matrix_core_pkg::*;
#(
  parameter int NUM_IN       = 12,
  parameter int NUM_OUT      = 12,
  parameter int PULSE_CYCLES = 25,
  parameter int LED_HOLD     = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  trig_in,
  output logic [NUM_OUT-1:0] trig_out,
  output logic [NUM_IN-1:0]  trig_in_led,
  output logic [NUM_OUT-1:0] trig_out_led,
  input  logic               cfg_wr_en,
  input  logic               cfg_rd_en,
  input  logic [7:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               cfg_rvalid
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);

  logic [NUM_IN-1:0]  sync_a;
  logic [NUM_IN-1:0]  sync_b;
  logic [255:0]       synced_ext;
  xbar_cfg_t          cfg [NUM_OUT];
  xbar_cfg_t          wr_cfg;
  logic [NUM_OUT-1:0] sel;
  logic [NUM_OUT-1:0] sel_prev;
  logic [NUM_OUT-1:0] wr_hit;
  logic [PW-1:0]      pulse_cnt [NUM_OUT];
  logic [15:0]        rd_word;
  logic               unused_rsvd;

  assign unused_rsvd = ^cfg_wdata[15:11];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= trig_in;
      sync_b <= sync_a;
    end
  end

  // Zero-extended to the full 8-bit source space so out-of-range selects read 0.
  always_comb begin
    synced_ext             = '0;
    synced_ext[NUM_IN-1:0] = sync_b;
  end

  always_comb begin
    sel = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if ({1'b0, cfg[o].src} < 9'(NUM_IN)) begin
        sel[o] = synced_ext[cfg[o].src] ^ cfg[o].invert;
      end
    end
  end

  always_comb begin
    wr_cfg = '{mode:   xbar_mode_e'(cfg_wdata[CFG_MODE_LSB +: CFG_MODE_W]),
               invert: cfg_wdata[CFG_INV_BIT],
               src:    cfg_wdata[CFG_SRC_LSB +: CFG_SRC_W]};
    wr_hit  = '0;
    rd_word = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      wr_hit[o] = cfg_wr_en && (cfg_addr == 8'(o));
      if (cfg_addr == 8'(o)) begin
        rd_word = cfg_pack(cfg[o]);
      end
    end
  end

  // On a write edge the output still follows the old config; the channel's
  // counter and edge history restart so the new config acts from the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_out <= '0;
      sel_prev <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        cfg[o]       <= XBAR_CFG_RESET;
        pulse_cnt[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        case (cfg[o].mode)
          XBAR_DIRECT: begin
            trig_out[o]  <= sel[o];
            pulse_cnt[o] <= '0;
          end
          XBAR_PULSE: begin
            if (sel[o] && !sel_prev[o]) begin
              pulse_cnt[o] <= PW'(PULSE_CYCLES);
              trig_out[o]  <= 1'b1;
            end else begin
              if (pulse_cnt[o] != '0) begin
                pulse_cnt[o] <= pulse_cnt[o] - PW'(1);
              end
              trig_out[o] <= (pulse_cnt[o] > PW'(1));
            end
          end
          default: begin
            trig_out[o]  <= 1'b0;
            pulse_cnt[o] <= '0;
          end
        endcase
        sel_prev[o] <= sel[o];
        if (wr_hit[o]) begin
          cfg[o]       <= wr_cfg;
          pulse_cnt[o] <= '0;
          sel_prev[o]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= cfg_rd_en;
      cfg_rdata  <= cfg_rd_en ? rd_word : 16'h0000;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in_led
    trigger_activity_stretcher #(.HOLD(LED_HOLD)) u_led (
      .clk (clk),
      .rst (rst),
      .sig (sync_b[i]),
      .led (trig_in_led[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_led
    trigger_activity_stretcher #(.HOLD(LED_HOLD)) u_led (
      .clk (clk),
      .rst (rst),
      .sig (trig_out[j]),
      .led (trig_out_led[j])
    );
  end

endmodule

// File: tb/tb_trigger_matrix_core.sv
// Self-checking bench for trigger_matrix_core: directed scenarios plus random
// traffic, every cycle compared against a history-window reference model.
module tb_trigger_matrix_core;

  localparam int NI   = 12;
  localparam int NO   = 12;
  localparam int PC   = 25;
  localparam int LH   = 8;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] trig_in;
  logic [NO-1:0] trig_out;
  logic [NI-1:0] trig_in_led;
  logic [NO-1:0] trig_out_led;
  logic          cfg_wr_en;
  logic          cfg_rd_en;
  logic [7:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic [15:0]   cfg_rdata;
  logic          cfg_rvalid;

  always #5 clk = ~clk;

  trigger_matrix_core #(
    .NUM_IN(NI), .NUM_OUT(NO), .PULSE_CYCLES(PC), .LED_HOLD(LH)
  ) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .trig_out(trig_out),
    .trig_in_led(trig_in_led), .trig_out_led(trig_out_led),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int last_rst = 0;

  // Value of each signal just after clock edge c.
  logic [NI-1:0] s1_h  [0:MAXC];
  logic [NI-1:0] syn_h [0:MAXC];
  logic [NO-1:0] out_h [0:MAXC];

  logic [7:0] m_src  [NO];
  logic       m_inv  [NO];
  logic [1:0] m_mode [NO];
  int         m_ep   [NO];

  logic [NI-1:0] exp_in_led;
  logic [NO-1:0] exp_out_led;
  logic          exp_rvalid;
  logic [15:0]   exp_rdata;

  function automatic logic sel_at(input int c, input int o);
    logic [NI-1:0] v;
    if (c < 0 || m_src[o] >= 8'(NI)) return 1'b0;
    v = syn_h[c] >> m_src[o];
    return v[0] ^ m_inv[o];
  endfunction

  task automatic model_update();
    int lo;
    logic rise, prv;
    if (rst) begin
      s1_h[n] = '0; syn_h[n] = '0; out_h[n] = '0;
      last_rst = n;
      for (int o = 0; o < NO; o++) begin
        m_src[o] = 8'h00; m_inv[o] = 1'b0; m_mode[o] = 2'b11; m_ep[o] = n;
      end
      exp_in_led = '0; exp_out_led = '0; exp_rvalid = 1'b0; exp_rdata = 16'h0;
      return;
    end
    s1_h[n]  = trig_in;
    syn_h[n] = s1_h[n-1];
    for (int o = 0; o < NO; o++) begin
      out_h[n][o] = 1'b0;
      if (m_mode[o] == 2'b00) begin
        out_h[n][o] = sel_at(n - 1, o);
      end else if (m_mode[o] == 2'b01) begin
        lo = (n - PC + 1 > m_ep[o] + 1) ? n - PC + 1 : m_ep[o] + 1;
        for (int j = lo; j <= n; j++) begin
          prv  = (j - 1 == m_ep[o]) ? 1'b0 : sel_at(j - 2, o);
          rise = sel_at(j - 1, o) && !prv;
          if (rise) out_h[n][o] = 1'b1;
        end
      end
    end
    lo = (n - LH > last_rst + 1) ? n - LH : last_rst + 1;
    exp_in_led = '0; exp_out_led = '0;
    for (int k = lo; k <= n - 1; k++) begin
      exp_in_led  = exp_in_led  | (syn_h[k] ^ syn_h[k-1]);
      exp_out_led = exp_out_led | (out_h[k] ^ out_h[k-1]);
    end
    exp_rvalid = cfg_rd_en;
    exp_rdata  = 16'h0;
    if (cfg_rd_en && cfg_addr < 8'(NO))
      exp_rdata = {5'b0, m_mode[cfg_addr], m_inv[cfg_addr], m_src[cfg_addr]};
    if (cfg_wr_en && cfg_addr < 8'(NO)) begin
      m_src[cfg_addr]  = cfg_wdata[7:0];
      m_inv[cfg_addr]  = cfg_wdata[8];
      m_mode[cfg_addr] = cfg_wdata[10:9];
      m_ep[cfg_addr]   = n;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, n, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    if (n >= MAXC) begin
      $display("FAIL history_overflow cycle %0d observed %0d expected below %0d", n, n, MAXC);
      $fatal(1);
    end
    model_update();
    #1;
    chk("trig_out", 32'(trig_out), 32'(out_h[n]));
    chk("trig_in_led", 32'(trig_in_led), 32'(exp_in_led));
    chk("trig_out_led", 32'(trig_out_led), 32'(exp_out_led));
    chk("cfg_rvalid", 32'(cfg_rvalid), 32'(exp_rvalid));
    if (exp_rvalid) chk("cfg_rdata", 32'(cfg_rdata), 32'(exp_rdata));
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] expect_word);
    cfg_rd_en = 1'b1; cfg_addr = a;
    tick();
    cfg_rd_en = 1'b0;
    chk("rd_directed", 32'(cfg_rdata), 32'(expect_word));
  endtask

  initial begin
    int cnt;
    int r;
    s1_h[0] = '0; syn_h[0] = '0; out_h[0] = '0;
    rst = 1'b1; trig_in = '0;
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = 8'h0; cfg_wdata = 16'h0;

    repeat (3) begin trig_in = NI'($urandom); tick(); end
    rst = 1'b0;
    repeat (10) begin trig_in = NI'($urandom); tick(); end
    chk("off_after_reset", 32'(trig_out), 32'h0);
    trig_in = '0;
    repeat (6) tick();

    for (int a = 0; a < NO; a++) rd(8'(a), 16'h0600);
    rd(8'd12, 16'h0000);

    wr(8'd3, 16'h0005);
    repeat (3) tick();
    trig_in[5] = 1'b1; repeat (8) tick();
    trig_in[5] = 1'b0; repeat (8) tick();
    wr(8'd3, 16'h0105);
    repeat (4) tick();
    trig_in[5] = 1'b1; repeat (8) tick();
    trig_in[5] = 1'b0; repeat (8) tick();

    wr(8'd0, 16'h0202);
    repeat (3) tick();
    trig_in[2] = 1'b1;
    cnt = 0;
    repeat (100) begin tick(); if (trig_out[0]) cnt++; end
    chk("pulse_width", 32'(cnt), 32'd25);
    trig_in[2] = 1'b0; repeat (10) tick();
    trig_in[2] = 1'b1;
    cnt = 0;
    repeat (5) begin tick(); if (trig_out[0]) cnt++; end
    trig_in[2] = 1'b0;
    repeat (5) begin tick(); if (trig_out[0]) cnt++; end
    trig_in[2] = 1'b1;
    repeat (60) begin tick(); if (trig_out[0]) cnt++; end
    chk("pulse_retrigger", 32'(cnt), 32'd35);
    trig_in[2] = 1'b0; repeat (5) tick();

    wr(8'd1, 16'h01FF);
    trig_in = '1; repeat (6) tick();
    chk("src_out_of_range", 32'(trig_out[1]), 32'h0);
    trig_in = '0;
    wr(8'h20, 16'h0003);
    rd(8'h20, 16'h0000);
    rd(8'd0, 16'h0202);
    wr(8'd4, 16'hF805);
    rd(8'd4, 16'h0005);
    repeat (LH + 4) tick();

    trig_in[7] = 1'b1;
    cnt = 0;
    repeat (20) begin tick(); if (trig_in_led[7]) cnt++; end
    chk("in_led_hold", 32'(cnt), 32'(LH));
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      trig_in[7] = ~trig_in[7];
      repeat (5) begin tick(); if (t > 0 && trig_in_led[7]) cnt++; end
    end
    chk("in_led_toggling", 32'(cnt), 32'd35);

    trig_in = '0; repeat (4) tick();
    trig_in[2] = 1'b1; repeat (8) tick();
    rst = 1'b1; tick();
    chk("rst_mid_pulse_out", 32'(trig_out), 32'h0);
    chk("rst_mid_pulse_led", 32'({trig_in_led, trig_out_led}), 32'h0);
    tick();
    rst = 1'b0; trig_in = '0;
    rd(8'd0, 16'h0600);

    // Random traffic: input toggles, config writes, reads, overlapping rd/wr, rare resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) trig_in = trig_in ^ (NI'(1) << $urandom_range(0, NI - 1));
      r = int'($urandom_range(0, 15));
      cfg_addr = 8'(r);
      if ($urandom_range(0, 9) == 0) begin
        cfg_wr_en = 1'b1;
        cfg_wdata = {5'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 14))};
      end
      if ($urandom_range(0, 7) == 0) cfg_rd_en = 1'b1;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      tick();
      cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
